// File: rtl/io_arbiter_pkg.sv
// ============================================================================
// Module  : io_arbiter_pkg
// Brief   : Shared IO-bus constants: address width and arbiter FSM encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package io_arbiter_pkg;

  localparam int unsigned IO_AW = 6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

endpackage : io_arbiter_pkg

`default_nettype wire

// File: rtl/io_arbiter.sv
// ============================================================================
// Module  : io_arbiter
// Brief   : Two-core round-robin arbiter onto one shared IO device bus, with
//           per-access timeout, abort data and registered read data per core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module io_arbiter
  import io_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [31:0] ERRDAT  = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd0,
  input  logic             wr0,
  input  logic [IO_AW-1:0] adr0,
  input  logic [31:0]      wdat0,
  input  logic             rd1,
  input  logic             wr1,
  input  logic [IO_AW-1:0] adr1,
  input  logic [31:0]      wdat1,
  output logic             stall0,
  output logic             stall1,
  output logic [31:0]      rdat0,
  output logic [31:0]      rdat1,
  output logic [IO_AW-1:0] dev_adr,
  output logic [31:0]      dev_wdat,
  output logic             dev_rd,
  output logic             dev_wr,
  input  logic [31:0]      dev_rdat,
  input  logic             dev_rdy,
  output logic             err
);

  localparam int unsigned   TW   = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  // Returns the granted core index; on contention the core not served last wins.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    return (r0 && r1) ? ~last : ~r0;
  endfunction

  logic             w_req0;
  logic             w_req1;
  logic             w_pick;
  logic             w_rd_cpl;
  logic [31:0]      w_rd_val;

  logic [1:0]       state_q,  state_d;
  logic             gnt_q,    gnt_d;
  logic             last_q,   last_d;
  logic [IO_AW-1:0] adr_q,    adr_d;
  logic [31:0]      wdat_q,   wdat_d;
  logic             wr_q,     wr_d;
  logic [TW-1:0]    timer_q,  timer_d;
  logic [31:0]      rdat0_q,  rdat0_d;
  logic [31:0]      rdat1_q,  rdat1_d;
  logic             err_q,    err_d;

  // A simultaneous read+write request counts as a write.
  assign w_req0 = rd0 | wr0;
  assign w_req1 = rd1 | wr1;
  assign w_pick = rr_pick(w_req0, w_req1, last_q);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    wr_d     = wr_q;
    timer_d  = timer_q;
    err_d    = 1'b0;
    w_rd_cpl = 1'b0;
    w_rd_val = dev_rdat;

    case (state_q)
      ST_IDLE: begin
        if (w_req0 || w_req1) begin
          gnt_d   = w_pick;
          last_d  = w_pick;
          adr_d   = w_pick ? adr1  : adr0;
          wdat_d  = w_pick ? wdat1 : wdat0;
          wr_d    = w_pick ? wr1   : wr0;
          timer_d = '0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // dev_rdy takes priority over an expiring timer.
        if (dev_rdy) begin
          w_rd_cpl = ~wr_q;
          w_rd_val = dev_rdat;
          state_d  = ST_DONE;
        end else if (timer_q == TMAX) begin
          w_rd_cpl = ~wr_q;
          w_rd_val = ERRDAT;
          err_d    = 1'b1;
          state_d  = ST_DONE;
        end else begin
          timer_d  = timer_q + TW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    rdat0_d = (w_rd_cpl && !gnt_q) ? w_rd_val : rdat0_q;
    rdat1_d = (w_rd_cpl &&  gnt_q) ? w_rd_val : rdat1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      adr_q   <= '0;
      wdat_q  <= '0;
      wr_q    <= 1'b0;
      timer_q <= '0;
      rdat0_q <= '0;
      rdat1_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      wr_q    <= wr_d;
      timer_q <= timer_d;
      rdat0_q <= rdat0_d;
      rdat1_q <= rdat1_d;
      err_q   <= err_d;
    end
  end

  // The granted core sees its stall drop only in the DONE cycle.
  assign stall0   = w_req0 & ~((state_q == ST_DONE) & ~gnt_q);
  assign stall1   = w_req1 & ~((state_q == ST_DONE) &  gnt_q);
  assign dev_rd   = (state_q == ST_ACCESS) & ~wr_q;
  assign dev_wr   = (state_q == ST_ACCESS) &  wr_q;
  assign dev_adr  = adr_q;
  assign dev_wdat = wdat_q;
  assign rdat0    = rdat0_q;
  assign rdat1    = rdat1_q;
  assign err      = err_q;

endmodule : io_arbiter

`default_nettype wire

// File: tb/tb_io_arbiter.sv
// ============================================================================
// Module  : tb_io_arbiter
// Brief   : Self-checking bench for io_arbiter: directed vector table, reset
//           sequences, fairness run and randomized transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_arbiter;

  localparam int          TO = 15;
  localparam logic [31:0] ED = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd0, wr0, rd1, wr1;
  logic [5:0]  adr0, adr1;
  logic [31:0] wdat0, wdat1;
  logic        stall0, stall1;
  logic [31:0] rdat0, rdat1;
  logic [5:0]  dev_adr;
  logic [31:0] dev_wdat;
  logic        dev_rd, dev_wr;
  logic [31:0] dev_rdat;
  logic        dev_rdy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  io_arbiter #(.TIMEOUT(TO), .ERRDAT(ED)) dut (
    .clk(clk), .rst(rst),
    .rd0(rd0), .wr0(wr0), .adr0(adr0), .wdat0(wdat0),
    .rd1(rd1), .wr1(wr1), .adr1(adr1), .wdat1(wdat1),
    .stall0(stall0), .stall1(stall1), .rdat0(rdat0), .rdat1(rdat1),
    .dev_adr(dev_adr), .dev_wdat(dev_wdat), .dev_rd(dev_rd), .dev_wr(dev_wr),
    .dev_rdat(dev_rdat), .dev_rdy(dev_rdy), .err(err)
  );

  // One access: both cores' request lines, device delay (ACCESS cycles before
  // dev_rdy; >= TO means never), device data, expected winner/err/read data.
  typedef struct {
    logic        r0, w0;
    logic [5:0]  a0;
    logic [31:0] d0;
    logic        r1, w1;
    logic [5:0]  a1;
    logic [31:0] d1;
    int          dly;
    logic [31:0] rdata;
    int          exp_w;
    logic        exp_err;
    logic [31:0] e0, e1;
  } vec_t;

  vec_t tbl[9];

  // Randomized transaction model state
  logic        pv[2], pr[2], pw[2];
  logic [5:0]  pa[2];
  logic [31:0] pd[2];
  logic [31:0] er[2];
  int          lg;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Starts at the negedge before an IDLE cycle, ends at the DONE-cycle negedge.
  task automatic run_access(input vec_t v, input bit drop);
    logic        wrdir;
    logic [5:0]  ea;
    logic [31:0] ewd;
    wrdir = (v.exp_w == 1) ? v.w1 : v.w0;
    ea    = (v.exp_w == 1) ? v.a1 : v.a0;
    ewd   = (v.exp_w == 1) ? v.d1 : v.d0;

    @(negedge clk);
    chk1("idle_dev_rd", dev_rd, 1'b0);
    chk1("idle_dev_wr", dev_wr, 1'b0);
    chk1("idle_err", err, 1'b0);
    rd0 = v.r0; wr0 = v.w0; adr0 = v.a0; wdat0 = v.d0;
    rd1 = v.r1; wr1 = v.w1; adr1 = v.a1; wdat1 = v.d1;
    dev_rdy = 1'b0; dev_rdat = v.rdata;
    #1;
    chk1("idle_stall0", stall0, rd0 | wr0);
    chk1("idle_stall1", stall1, rd1 | wr1);

    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      chk1("acc_dev_rd", dev_rd, ~wrdir);
      chk1("acc_dev_wr", dev_wr, wrdir);
      chk32("acc_dev_adr", 32'(dev_adr), 32'(ea));
      chk32("acc_dev_wdat", dev_wdat, ewd);
      chk1("acc_err", err, 1'b0);
      chk1("acc_stall0", stall0, rd0 | wr0);
      chk1("acc_stall1", stall1, rd1 | wr1);
      dev_rdy = (k == v.dly);
      if (drop && k == 0) begin
        if (v.exp_w == 1) begin rd1 = 1'b0; wr1 = 1'b0; end
        else              begin rd0 = 1'b0; wr0 = 1'b0; end
      end
      if (k == v.dly) break;
    end

    @(negedge clk);
    chk1("done_stall0", stall0, (rd0 | wr0) && (v.exp_w == 1));
    chk1("done_stall1", stall1, (rd1 | wr1) && (v.exp_w == 0));
    chk1("done_dev_rd", dev_rd, 1'b0);
    chk1("done_err", err, v.exp_err);
    chk32("done_rdat0", rdat0, v.e0);
    chk32("done_rdat1", rdat1, v.e1);
    dev_rdy = 1'b0;
    if (v.exp_w == 1) begin rd1 = 1'b0; wr1 = 1'b0; end
    else              begin rd0 = 1'b0; wr0 = 1'b0; end
  endtask

  task automatic gen_req(input int c);
    logic [1:0] dir;
    dir   = 2'($urandom_range(1, 3));
    pv[c] = 1'b1;
    pr[c] = dir[0];
    pw[c] = dir[1];
    pa[c] = 6'($urandom);
    pd[c] = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   w, dly;
    logic tmo;
    logic [31:0] data;

    //          r0 w0 a0     d0            r1 w1 a1     d1            dly rdata         w  err e0            e1
    tbl[0] = '{1'b1,1'b0,6'h01,32'h0,        1'b0,1'b1,6'h02,32'hA5A5_A5A5, 0,  32'h1111_1111, 0, 1'b0, 32'h1111_1111, 32'h0};
    tbl[1] = '{1'b0,1'b0,6'h00,32'h0,        1'b0,1'b1,6'h02,32'hA5A5_A5A5, 0,  32'h2222_2222, 1, 1'b0, 32'h1111_1111, 32'h0};
    tbl[2] = '{1'b1,1'b0,6'h3C,32'h0,        1'b0,1'b0,6'h00,32'h0,         2,  32'h1234_5678, 0, 1'b0, 32'h1234_5678, 32'h0};
    tbl[3] = '{1'b0,1'b0,6'h00,32'h0,        1'b1,1'b0,6'h10,32'h0,         99, 32'h3333_3333, 1, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF};
    tbl[4] = '{1'b1,1'b0,6'h20,32'h0,        1'b0,1'b0,6'h00,32'h0,         14, 32'hCAFE_BABE, 0, 1'b0, 32'hCAFE_BABE, 32'hFFFF_FFFF};
    tbl[5] = '{1'b1,1'b1,6'h2A,32'hDEAD_BEEF,1'b0,1'b0,6'h00,32'h0,         5,  32'h5555_5555, 0, 1'b0, 32'hCAFE_BABE, 32'hFFFF_FFFF};
    tbl[6] = '{1'b1,1'b0,6'h07,32'h0,        1'b1,1'b0,6'h3F,32'h0,         13, 32'h0BAD_F00D, 1, 1'b0, 32'hCAFE_BABE, 32'h0BAD_F00D};
    tbl[7] = '{1'b1,1'b0,6'h07,32'h0,        1'b0,1'b0,6'h00,32'h0,         1,  32'h7777_7777, 0, 1'b0, 32'h7777_7777, 32'h0BAD_F00D};
    tbl[8] = '{1'b0,1'b0,6'h00,32'h0,        1'b1,1'b0,6'h11,32'h0,         15, 32'h9999_9999, 1, 1'b1, 32'h7777_7777, 32'hFFFF_FFFF};

    rst = 1'b0;
    rd0 = 1'b1; wr0 = 1'b0; adr0 = '0; wdat0 = '0;
    rd1 = 1'b0; wr1 = 1'b0; adr1 = '0; wdat1 = '0;
    dev_rdy = 1'b0; dev_rdat = '0;

    // Reset state; stall follows the request while in reset
    repeat (2) @(negedge clk);
    chk1("rst_dev_rd", dev_rd, 1'b0);
    chk1("rst_dev_wr", dev_wr, 1'b0);
    chk32("rst_dev_adr", 32'(dev_adr), 32'h0);
    chk32("rst_dev_wdat", dev_wdat, 32'h0);
    chk32("rst_rdat0", rdat0, 32'h0);
    chk32("rst_rdat1", rdat1, 32'h0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_stall0", stall0, 1'b1);
    chk1("rst_stall1", stall1, 1'b0);

    // Reset during a pending read
    rst = 1'b1; adr0 = 6'h05;
    @(negedge clk);
    chk1("mid_dev_rd", dev_rd, 1'b1);
    chk32("mid_dev_adr", 32'(dev_adr), 32'h05);
    @(negedge clk);
    rst = 1'b0; dev_rdy = 1'b1; dev_rdat = 32'hDEAD_0001;
    @(negedge clk);
    chk1("midrst_dev_rd", dev_rd, 1'b0);
    chk1("midrst_err", err, 1'b0);
    chk32("midrst_rdat0", rdat0, 32'h0);
    chk1("midrst_stall0", stall0, 1'b1);
    @(negedge clk);
    chk1("midrst_err2", err, 1'b0);
    chk32("midrst_rdat0_2", rdat0, 32'h0);
    rst = 1'b1; rd0 = 1'b0; dev_rdy = 1'b0;

    for (int i = 0; i < 9; i++) run_access(tbl[i], 1'b0);

    // Fairness: both cores request writes continuously
    for (int i = 0; i < 8; i++) begin
      v = '{1'b0, 1'b1, 6'(i), 32'h100 + 32'(i), 1'b0, 1'b1, 6'(i + 32), 32'h200 + 32'(i),
            i % 3, 32'h0, i % 2, 1'b0, 32'h7777_7777, 32'hFFFF_FFFF};
      run_access(v, 1'b0);
    end

    // Randomized traffic against the transaction model
    lg = 1;
    er[0] = 32'h7777_7777; er[1] = 32'hFFFF_FFFF;
    pv[0] = 1'b0; pv[1] = 1'b0;
    for (int it = 0; it < 60; it++) begin
      for (int c = 0; c < 2; c++)
        if (!pv[c] && $urandom_range(0, 2) != 0) gen_req(c);
      if (!pv[0] && !pv[1]) gen_req(int'($urandom_range(0, 1)));
      w    = (pv[0] && pv[1]) ? 1 - lg : (pv[0] ? 0 : 1);
      lg   = w;
      dly  = int'($urandom_range(0, TO + 3));
      data = $urandom;
      tmo  = (dly >= TO);
      if (!pw[w]) er[w] = tmo ? ED : data;
      v = '{pv[0] & pr[0], pv[0] & pw[0], pa[0], pd[0],
            pv[1] & pr[1], pv[1] & pw[1], pa[1], pd[1],
            dly, data, w, tmo, er[0], er[1]};
      run_access(v, ($urandom_range(0, 3) == 0));
      pv[w] = 1'b0;
    end

    @(negedge clk);
    chk1("final_err", err, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_io_arbiter

`default_nettype wire
